// File: rtl/pal_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pal_pkg
// Brief    : Shared PAL configuration-loader types, CRC polynomial and sizing.
// Revision : 1.0
// ============================================================================
package pal_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_SHIFT_LO = 3'd2,
      ST_SHIFT_HI = 3'd3,
      ST_APPLY    = 3'd4
   } pal_state_e;

   localparam logic [7:0] c_CRC_POLY = 8'h07;

   // Two literals per input for each product term, plus one OR-plane bit per term/output.
   function automatic int unsigned cfg_bits(input int unsigned n, input int unsigned m,
                                            input int unsigned p);
      return 2 * n * p + p * m;
   endfunction

   function automatic int unsigned num_bytes(input int unsigned n, input int unsigned m,
                                             input int unsigned p);
      return (cfg_bits(n, m, p) + 7) / 8;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pal_cfg_crc8.sv
`default_nettype none
// ============================================================================
// Module   : pal_cfg_crc8
// Brief    : Bit-serial CRC-8 (MSB-first, init 0x00) over the shifted config bits.
// Revision : 1.0
// ============================================================================
module pal_cfg_crc8
   import pal_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic       i_bit,
   output logic [7:0] o_crc
);

   logic [7:0] r_crc;
   logic       w_fb;

   assign w_fb  = r_crc[7] ^ i_bit;
   assign o_crc = r_crc;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_crc <= 8'h00;
      end else if (i_en) begin
         r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? c_CRC_POLY : 8'h00);
      end
   end

endmodule
`default_nettype wire

// File: rtl/pal_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : pal_cfg_loader
// Brief    : Streams a PAL bitstream from a byte interface into a serial config
//            chain. Define PAL_CFG_CRC_EN to check a trailing CRC-8 byte.
// Revision : 1.0
// ============================================================================
module pal_cfg_loader
   import pal_pkg::*;
#(
   parameter int unsigned N       = 8,
   parameter int unsigned M       = 8,
   parameter int unsigned P       = 11,
   parameter int unsigned CLK_DIV = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   output logic       cfg_clk,
   output logic       cfg_data,
   output logic       cfg_en,
   output logic       busy,
   output logic       done,
   output logic       crc_err
);

   localparam int unsigned c_CFG_BITS = cfg_bits(N, M, P);
   localparam int          c_BIT_W    = $clog2(c_CFG_BITS + 1);
   localparam int          c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(c_CFG_BITS);
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
`ifdef PAL_CFG_CRC_EN
   localparam bit c_HAS_CRC = 1'b1;
`else
   localparam bit c_HAS_CRC = 1'b0;
`endif

   pal_state_e         r_state, w_state_nxt;
   logic [c_BIT_W-1:0] r_bit_cnt;
   logic [2:0]         r_bit_in_byte;
   logic [7:0]         r_shift;
   logic [c_DIV_W-1:0] r_div;
   logic               r_cfg_en;
   logic               w_accept, w_div_last, w_last_bit, w_shifting, w_load_start;
   logic               w_crc_phase, w_crc_bad;

   assign w_accept     = s_ready && s_valid;
   assign w_div_last   = (r_div == c_DIV_LAST);
   assign w_last_bit   = ((r_bit_cnt + 1'b1) == c_LAST_BIT);
   assign w_shifting   = (r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI);
   assign w_load_start = (r_state == ST_IDLE) && start;
   assign cfg_en       = r_cfg_en;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:     if (start) w_state_nxt = ST_FETCH;
         ST_FETCH:    if (w_accept) w_state_nxt = w_crc_phase ? ST_APPLY : ST_SHIFT_LO;
         ST_SHIFT_LO: if (w_div_last) w_state_nxt = ST_SHIFT_HI;
         ST_SHIFT_HI: begin
            if (w_div_last) begin
               if (w_last_bit)                w_state_nxt = c_HAS_CRC ? ST_FETCH : ST_APPLY;
               else if (r_bit_in_byte == 3'd7) w_state_nxt = ST_FETCH;
               else                           w_state_nxt = ST_SHIFT_LO;
            end
         end
         ST_APPLY:    w_state_nxt = ST_IDLE;
         default:     w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ready  = (r_state == ST_FETCH);
      busy     = (r_state != ST_IDLE);
      cfg_clk  = (r_state == ST_SHIFT_HI);
      cfg_data = w_shifting ? r_shift[7] : 1'b0;
      done     = (r_state == ST_APPLY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bit_cnt     <= '0;
         r_bit_in_byte <= 3'd0;
         r_shift       <= 8'h00;
         r_div         <= '0;
         r_cfg_en      <= 1'b0;
      end else begin
         r_div <= (w_shifting && !w_div_last) ? r_div + 1'b1 : '0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_bit_cnt     <= '0;
                  r_bit_in_byte <= 3'd0;
                  r_cfg_en      <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (w_accept) begin
                  r_shift       <= s_data;
                  r_bit_in_byte <= 3'd0;
               end
            end
            ST_SHIFT_HI: begin
               if (w_div_last) begin
                  r_bit_cnt     <= r_bit_cnt + 1'b1;
                  r_bit_in_byte <= r_bit_in_byte + 3'd1;
                  r_shift       <= {r_shift[6:0], 1'b0};
               end
            end
            ST_APPLY: r_cfg_en <= !w_crc_bad;
            default: ;
         endcase
      end
   end

`ifdef PAL_CFG_CRC_EN
   logic       r_crc_phase, r_crc_err;
   logic [7:0] w_crc;

   // The check byte is fetched after the last data bit; compare it on accept.
   always_ff @(posedge clk) begin
      if (rst || w_load_start) begin
         r_crc_phase <= 1'b0;
         r_crc_err   <= 1'b0;
      end else if ((r_state == ST_SHIFT_HI) && w_div_last && w_last_bit) begin
         r_crc_phase <= 1'b1;
      end else if (w_accept && r_crc_phase) begin
         r_crc_err   <= (s_data != w_crc);
      end
   end

   pal_cfg_crc8 u_crc (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_load_start),
      .i_en  ((r_state == ST_SHIFT_HI) && w_div_last),
      .i_bit (r_shift[7]),
      .o_crc (w_crc)
   );

   assign w_crc_phase = r_crc_phase;
   assign w_crc_bad   = r_crc_err;
   assign crc_err     = r_crc_err;
`else
   assign w_crc_phase = 1'b0;
   assign w_crc_bad   = 1'b0;
   assign crc_err     = 1'b0;
`endif

endmodule
`default_nettype wire
